// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: the MEM-stage FSM encodings, the data-memory
// timeout default and the MEM/WB control width.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int CTRL_WB_W           = 2;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack bus. The controller drives it through the master modport and the memory
// through the slave modport. Request fields hold steady until ack; rdata is valid in the ack cycle.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// WAIT-cycle counter: clr loads 0, inc counts up and saturates at all-ones; the count is visible the cycle after.
// tc flags the last permitted WAIT cycle (count == TERM-1). There is no backpressure.
module mem_wait_timer #(
  parameter int TERM = 255,
  parameter int W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(TERM - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: a load/store goes IDLE -> WAIT (req until ack or timeout) -> DONE, 3 cycles minimum.
// It stalls the upstream latches and bubbles MEM/WB until DONE. Non-memory instructions pass with no added latency.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  mem_access_ctrl_if.master mem,
  output logic              stall,
  output logic              memwb_bubble,
  output logic [DATA_W-1:0] read_data_out,
  output logic              mem_err,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmr_clr, tmr_inc, tmr_tc;
  logic              hold;
  logic              access;

  assign access = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);

  mem_wait_timer #(
    .TERM (TIMEOUT_CYCLES),
    .W    (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    hold    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          hold    = 1'b1;
          we_d    = ex_mem_memwrite;
          addr_d  = ex_mem_addr;
          wdata_d = ex_mem_wdata;
          tmr_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        hold = 1'b1;
        if (mem.dmem_ack) begin
          // A store keeps the previous read data so MEM/WB sees no stray value.
          if (!we_q) begin
            rdata_d = mem.dmem_rdata;
          end
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The IDLE decode is combinational on ex_mem_*, so it must be masked while reset is low.
  assign stall          = hold & rst_n;
  assign memwb_bubble   = hold & rst_n;
  assign mem.dmem_req   = (state_q == ST_WAIT);
  assign mem.dmem_we    = we_q;
  assign mem.dmem_addr  = addr_q;
  assign mem.dmem_wdata = wdata_q;
  assign read_data_out  = rdata_q;
  assign mem_err        = err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
